// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit_if : request/response handshake between pipeline and     |
// |                      the memory access unit                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_is_store, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_is_store, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_unit : single-outstanding load/store unit with fault check;   |
// |                   MAU_STORE_VERIFY_EN adds a read-back check to stores   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_unit (
  input  wire              clk,
  input  wire              rst_n,
  mem_access_unit_if.slave bus,
  output logic             read_data_flag,
  output logic             write_data_flag,
  output logic [7:0]       address_of_data,
  output logic [31:0]      data_to_write,
  input  wire  [31:0]      data_read_out
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
`ifdef MAU_STORE_VERIFY_EN
  localparam logic [2:0] S_VRD1  = 3'd4;
  localparam logic [2:0] S_VRD2  = 3'd5;
`endif

  logic [2:0]  r_state;
  logic        r_is_store;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_addr_fault;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign w_accept       = bus.req_valid && bus.req_ready;
  // Misaligned word access or beyond the 1 KiB data memory window.
  assign w_addr_fault   = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:10] != 22'd0);

  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_fault = r_fault;
  assign address_of_data = r_addr;
  assign data_to_write   = r_wdata;

  always_comb begin
    read_data_flag  = 1'b0;
    write_data_flag = 1'b0;
    case (r_state)
      S_ISSUE: begin
        read_data_flag  = !r_is_store;
        write_data_flag = r_is_store;
      end
      S_WAIT:  read_data_flag = 1'b1;
`ifdef MAU_STORE_VERIFY_EN
      S_VRD1:  read_data_flag = 1'b1;
      S_VRD2:  read_data_flag = 1'b1;
`endif
      default: begin
        read_data_flag  = 1'b0;
        write_data_flag = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_is_store <= 1'b0;
      r_addr     <= 8'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_store <= bus.req_is_store;
            r_addr     <= bus.req_addr[9:2];
            r_wdata    <= bus.req_wdata;
            if (w_addr_fault) begin
              r_state <= S_RESP;
              r_rdata <= 32'd0;
              r_fault <= 1'b1;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (r_is_store) begin
`ifdef MAU_STORE_VERIFY_EN
            r_state <= S_VRD1;
`else
            r_state <= S_RESP;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
`endif
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_state <= S_RESP;
          r_rdata <= data_read_out;
          r_fault <= 1'b0;
        end
`ifdef MAU_STORE_VERIFY_EN
        S_VRD1: r_state <= S_VRD2;
        S_VRD2: begin
          // Read-back must match what was written in ISSUE.
          r_state <= S_RESP;
          r_rdata <= 32'd0;
          r_fault <= (data_read_out != r_wdata);
        end
`endif
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1; one clock, reset asynchronous and active-low.
REQ-003 SHALL have port req_valid, input, 1, pipeline memory request present.
REQ-004 SHALL have port req_ready, output, 1, unit idle and able to accept.
REQ-005 SHALL have port req_is_store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port req_addr, input, 32, byte address.
REQ-007 SHALL have port req_wdata, input, 32, store data.
REQ-008 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port resp_rdata, output, 32, load result (0 for store/fault).
REQ-010 SHALL have port resp_fault, output, 1, access rejected; qualified by resp_valid.
REQ-011 SHALL have ports read_data_flag, write_data_flag (output, 1), address_of_data (output, 8), data_to_write (output, 32), data_read_out (input, 32), wired to the data memory.

Function
REQ-012 SHALL accept a request on a rising edge where req_valid=1 and req_ready=1; req_ready = (state==IDLE).
REQ-013 SHALL register req_is_store, req_addr and req_wdata at acceptance; inputs SHALL be ignored outside acceptance.
REQ-014 SHALL form word address = req_addr[9:2] on address_of_data.
REQ-015 SHALL flag a fault if req_addr[1:0]!=0 (misaligned) or req_addr[31:10]!=0 (out of range).
REQ-016 SHALL use FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 Fault: IDLE->RESP at acceptance edge; no memory flag asserted; resp_fault=1, resp_rdata=0.
REQ-018 Load: IDLE->ISSUE->WAIT->RESP; read_data_flag=1 in ISSUE and WAIT; resp_rdata captured from data_read_out on the WAIT->RESP edge; resp_valid high 3 edges after acceptance.
REQ-019 Store: IDLE->ISSUE->RESP; write_data_flag=1 and data_to_write=registered wdata for exactly the ISSUE cycle; read_data_flag=0; resp_valid high 2 edges after acceptance.
REQ-020 RESP SHALL last exactly one cycle then return to IDLE; resp_valid=1 only in RESP.
REQ-021 resp_rdata and resp_fault SHALL hold their value until the next RESP.
REQ-022 read_data_flag and write_data_flag SHALL never both be 1.
REQ-023 address_of_data and data_to_write SHALL be stable from ISSUE through the last memory-access cycle.
REQ-024 Throughput: a new request is accepted the edge after RESP at earliest; back-to-back loads complete every 4 cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, resp_valid=0, resp_fault=0, resp_rdata=0, both memory flags=0, address_of_data=0, data_to_write=0.
REQ-026 No request SHALL be accepted while rst_n=0.
REQ-027 Reset mid-operation SHALL abort the access with no resp_valid; a store already issued in ISSUE is not undone.

Configuration
REQ-028 Macro MAU_STORE_VERIFY_EN: when defined, a store SHALL go ISSUE->VRD1->VRD2->RESP, with read_data_flag=1 in VRD1/VRD2, and resp_fault=1 if data_read_out sampled on VRD2->RESP differs from stored data; resp_valid 4 edges after acceptance.
REQ-029 Without MAU_STORE_VERIFY_EN, states VRD1/VRD2 SHALL not exist and stores follow REQ-019.

Verification (data memory preloaded mem[i]=i)
REQ-030 Load 0x0000_0014 -> address_of_data=5, resp_rdata=5, resp_fault=0, resp_valid 3 edges after accept.
REQ-031 Store 0xDEADBEEF to 0x40, then load 0x40 -> write_data_flag high one cycle with address 16; load returns 0xDEADBEEF.
REQ-032 Load 0x0000_0002 -> resp_fault=1, resp_rdata=0, no memory flag asserted, resp_valid 1 edge after accept; load 0x0000_0400 -> same fault result.
REQ-033 rst_n pulsed low during WAIT of load 0x8 -> flags drop without waiting for clk, no resp_valid; subsequent load 0x8 returns 2.
REQ-034 req_valid held high for 3 loads 0x0, 0x4, 0x8 -> responses 0, 1, 2, accepts spaced 4 cycles, req_ready low while busy.
REQ-035 With MAU_STORE_VERIFY_EN: store 0x5 to 0x3FC -> resp_valid 4 edges after accept, resp_fault=0; memory forced to mismatch -> resp_fault=1.
